// File: rtl/debounce_switch_multi.sv
// -----------------------------------------------------------------------------
// debounce_switch_multi
//
// WIDTH-channel switch/button debouncer. A shared prescaler produces a sample
// tick every RATE clocks; each channel shifts its (optionally inverted) input
// into an N-deep history on every tick. The debounced state follows the input
// only once all N history bits agree. Registered rise/fall strobes, sticky
// write-1-to-clear change events and a maskable interrupt are provided.
//
// Optional build macro:
//   DEBOUNCE_SYNC_EN  adds a two-flop synchroniser per channel ahead of the
//                     sampler (+2 cycles input latency). When undefined the
//                     raw inputs must already be synchronous to clk.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   enable_i     1 = prescaler runs; 0 = prescaler held, no sampling
//   in_i         raw inputs, one bit per channel
//   out_o        debounced state
//   rise_o       one-cycle strobe, out_o[i] went 0->1 (cycle after the change)
//   fall_o       one-cycle strobe, out_o[i] went 1->0 (cycle after the change)
//   event_clr_i  write-1-to-clear for event_o, sampled every cycle
//   event_o      sticky change flags (set wins over clear)
//   irq_mask_i   1 = channel contributes to irq_o
//   irq_o        registered OR of (event_o & irq_mask_i)
// -----------------------------------------------------------------------------
module debounce_switch_multi #(
    parameter int               WIDTH  = 13,
    parameter int               N      = 4,
    parameter int               RATE   = 125000,
    parameter logic [WIDTH-1:0] INVERT = '0,
    parameter logic [WIDTH-1:0] INIT   = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    input  logic [WIDTH-1:0] event_clr_i,
    output logic [WIDTH-1:0] event_o,
    input  logic [WIDTH-1:0] irq_mask_i,
    output logic             irq_o
);

    // RATE = 1 still needs a 1-bit counter (always 0, tick every cycle).
    localparam int            CW         = (RATE > 1) ? $clog2(RATE) : 1;
    localparam logic [CW-1:0] COUNT_LAST = CW'(RATE - 1);

    typedef logic [WIDTH-1:0][N-1:0] hist_t;

    // History reset value: every sample slot of channel i holds INIT[i], so the
    // channel starts out "settled" at its reset level.
    function automatic hist_t init_hist();
        hist_t h;
        for (int i = 0; i < WIDTH; i++) begin
            h[i] = {N{INIT[i]}};
        end
        return h;
    endfunction

    localparam hist_t HIST_RST = init_hist();

    // -------------------------------------------------------------------------
    // Input stage
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] in_s;
    logic [WIDTH-1:0] in_eff;

`ifdef DEBOUNCE_SYNC_EN
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Synchroniser resets to the raw level that maps onto INIT after
    // inversion, so leaving reset never looks like an input transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= INIT ^ INVERT;
            sync2_q <= INIT ^ INVERT;
        end else begin
            sync1_q <= in_i;
            sync2_q <= sync1_q;
        end
    end

    assign in_s = sync2_q;
`else
    assign in_s = in_i;
`endif

    assign in_eff = in_s ^ INVERT;

    // -------------------------------------------------------------------------
    // Shared prescaler
    // -------------------------------------------------------------------------
    logic [CW-1:0] count_q, count_d;
    logic          tick_q, tick_d;
    logic          sample_en;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (enable_i) begin
            tick_d  = (count_q == COUNT_LAST);
            count_d = (count_q == COUNT_LAST) ? '0 : count_q + CW'(1);
        end
    end

    // A tick already registered is suppressed if enable drops that cycle.
    assign sample_en = tick_q & enable_i;

    // -------------------------------------------------------------------------
    // Per-channel history and debounced state
    // -------------------------------------------------------------------------
    hist_t            hist_q, hist_d;
    logic [WIDTH-1:0] out_q, out_d;

    // The state decision looks at the history including the sample taken this
    // tick, so the change lands on the cycle after the Nth agreeing tick.
    always_comb begin
        hist_d = hist_q;
        out_d  = out_q;
        if (sample_en) begin
            for (int i = 0; i < WIDTH; i++) begin
                hist_d[i] = {hist_q[i][N-2:0], in_eff[i]};
                if (&hist_d[i]) begin
                    out_d[i] = 1'b1;
                end else if (~|hist_d[i]) begin
                    out_d[i] = 1'b0;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Edge strobes, sticky events, interrupt
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] out_prev_q;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] event_q, event_d;
    logic             irq_q, irq_d;

    always_comb begin
        rise_d  = out_q & ~out_prev_q;
        fall_d  = ~out_q & out_prev_q;
        // Set has priority over a coincident clear so no change is lost.
        event_d = (event_q & ~event_clr_i) | rise_q | fall_q;
        irq_d   = |(event_q & irq_mask_i);
    end

    // NOTE: sequential state is written only with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            tick_q     <= 1'b0;
            // NOTE: the history array is explicitly reset; it defines the
            // starting debounced level and must not power up as X.
            hist_q     <= HIST_RST;
            out_q      <= INIT;
            // Previous-state copy starts equal to out, so reset emits no strobe.
            out_prev_q <= INIT;
            rise_q     <= '0;
            fall_q     <= '0;
            event_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            tick_q     <= tick_d;
            hist_q     <= hist_d;
            out_q      <= out_d;
            out_prev_q <= out_q;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            event_q    <= event_d;
            irq_q      <= irq_d;
        end
    end

    assign out_o   = out_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign event_o = event_q;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_debounce_switch_multi.sv
// -----------------------------------------------------------------------------
// tb_debounce_switch_multi
//
// Driver applies inputs on the falling edge, advances a behavioural model by
// one clock and pushes the expected register outputs into a queue. A separate
// monitor pops one entry after every rising edge and compares. The model
// tracks, per channel, the value and length of the current run of agreeing
// samples: a run of N or more equal samples defines the debounced state.
// -----------------------------------------------------------------------------
module tb_debounce_switch_multi;

    localparam int         WIDTH  = 4;
    localparam int         N      = 4;
    localparam int         RATE   = 5;
    localparam logic [3:0] INVERT = 4'b0100;
    localparam logic [3:0] INIT   = 4'b0000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] din, clr, mask;
    logic [3:0] dout, rise, fall, evt;
    logic       irq;

    always #5 clk = ~clk;

    debounce_switch_multi #(
        .WIDTH (WIDTH),
        .N     (N),
        .RATE  (RATE),
        .INVERT(INVERT),
        .INIT  (INIT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_i   (en),
        .in_i       (din),
        .out_o      (dout),
        .rise_o     (rise),
        .fall_o     (fall),
        .event_clr_i(clr),
        .event_o    (evt),
        .irq_mask_i (mask),
        .irq_o      (irq)
    );

    typedef struct packed {
        logic [3:0] out;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] ev;
        logic       irq;
    } resp_t;

    resp_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    // ------------------------------------------------------------------ model
    int         enabled_cycles;
    bit         m_tick;
    int         run_len[WIDTH];
    bit         run_val[WIDTH];
    logic [3:0] m_out, m_last_out, m_rise, m_fall, m_ev;
    logic       m_irq;

    function automatic void model_reset();
        enabled_cycles = 0;
        m_tick         = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            run_val[i] = INIT[i];
            run_len[i] = N;
        end
        m_out      = INIT;
        m_last_out = INIT;
        m_rise     = '0;
        m_fall     = '0;
        m_ev       = '0;
        m_irq      = 1'b0;
    endfunction

    // Advance by one rising edge using the inputs currently applied.
    function automatic void model_step();
        bit         sample;
        bit         new_tick;
        logic [3:0] new_out;
        if (!rst_n) begin
            model_reset();
            return;
        end
        sample   = m_tick && en;
        new_tick = en && ((enabled_cycles % RATE) == RATE - 1);
        if (en) enabled_cycles++;
        new_out = m_out;
        if (sample) begin
            for (int i = 0; i < WIDTH; i++) begin
                bit b;
                b = din[i] ^ INVERT[i];
                if (b == run_val[i]) run_len[i]++;
                else begin
                    run_val[i] = b;
                    run_len[i] = 1;
                end
                if (run_len[i] >= N) new_out[i] = run_val[i];
            end
        end
        m_irq      = |(m_ev & mask);
        m_ev       = (m_ev & ~clr) | m_rise | m_fall;
        m_rise     = m_out & ~m_last_out;
        m_fall     = ~m_out & m_last_out;
        m_last_out = m_out;
        m_out      = new_out;
        m_tick     = new_tick;
    endfunction

    // ---------------------------------------------------------------- checking
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s t=%0t got=%0h required=%0h", name, $time, got, req);
        end
    endtask

    initial begin : monitor
        resp_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = '{out: dout, rise: rise, fall: fall, ev: evt, irq: irq};
                vectors++;
                if (g !== e) begin
                    miscompares++;
                    $display("FAIL scoreboard t=%0t got out=%b rise=%b fall=%b event=%b irq=%b required out=%b rise=%b fall=%b event=%b irq=%b",
                             $time, g.out, g.rise, g.fall, g.ev, g.irq, e.out, e.rise, e.fall, e.ev, e.irq);
                end
            end
        end
    end

    // ----------------------------------------------------------------- driver
    logic [3:0] obs_out, obs_rise, obs_fall, obs_ev;
    logic       obs_irq;

    task automatic wait_neg();
        @(negedge clk);
        obs_out  = dout;
        obs_rise = rise;
        obs_fall = fall;
        obs_ev   = evt;
        obs_irq  = irq;
    endtask

    task automatic apply(input logic e, input logic [3:0] i, input logic [3:0] c, input logic [3:0] m);
        en   = e;
        din  = i;
        clr  = c;
        mask = m;
        model_step();
        exp_q.push_back('{out: m_out, rise: m_rise, fall: m_fall, ev: m_ev, irq: m_irq});
    endtask

    task automatic cyc(input logic e, input logic [3:0] i, input logic [3:0] c, input logic [3:0] m);
        wait_neg();
        apply(e, i, c, m);
    endtask

    initial begin : driver
        logic [3:0] acc_a, acc_b, acc_c, frozen, cur_in, cur_mask;
        int         rise0_cnt, rise2_cnt, fall2_cnt;
        bit         found;

        rst_n = 1'b0;
        en    = 1'b1;
        din   = '0;
        clr   = '0;
        mask  = '0;
        model_reset();
        for (int k = 0; k < 3; k++) cyc(1'b1, 4'b0000, 4'b0000, 4'b0000);

        // Reset outputs.
        check("reset_out", {28'd0, dout}, {28'd0, INIT});
        check("reset_event_irq", {27'd0, evt, irq}, 32'd0);

        // Hold in[0]=1; in[2]=0 is inverted, so channel 2 also settles high.
        wait_neg();
        rst_n = 1'b1;
        apply(1'b1, 4'b0001, 4'b0000, 4'b0000);
        rise0_cnt = 0;
        rise2_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 4'b0001, 4'b0000, 4'b0000);
            rise0_cnt += int'(obs_rise[0]);
            rise2_cnt += int'(obs_rise[2]);
        end
        check("hold_out0", {31'd0, obs_out[0]}, 32'd1);
        check("rise0_once", rise0_cnt, 1);
        check("invert_out2", {31'd0, obs_out[2]}, 32'd1);
        check("rise2_once", rise2_cnt, 1);
        check("event_after_rise", {28'd0, obs_ev}, 32'h5);

        // Glitch on channel 1: exactly 3 ticks high, then low.
        acc_a = '0;
        for (int k = 0; k < 45; k++) begin
            cyc(1'b1, (k < 15) ? 4'b0011 : 4'b0001, 4'b0000, 4'b0000);
            acc_a |= {obs_out[1], obs_rise[1], obs_fall[1], obs_ev[1]};
        end
        check("glitch_ch1_quiet", {28'd0, acc_a}, 32'd0);

        // Channel 2 input high: inverted level falls once.
        fall2_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 4'b0101, 4'b0000, 4'b0000);
            fall2_cnt += int'(obs_fall[2]);
        end
        check("fall2_once", fall2_cnt, 1);
        check("fall2_out", {31'd0, obs_out[2]}, 32'd0);

        // Events and interrupt on channel 0 only.
        cyc(1'b1, 4'b0101, 4'b1111, 4'b0001);
        for (int k = 0; k < 3; k++) cyc(1'b1, 4'b0101, 4'b0000, 4'b0001);
        check("clear_all_events", {28'd0, obs_ev}, 32'd0);
        for (int k = 0; k < 40; k++) cyc(1'b1, 4'b0100, 4'b0000, 4'b0001);
        check("irq_after_fall0", {31'd0, obs_irq}, 32'd1);
        cyc(1'b1, 4'b0100, 4'b1111, 4'b0001);
        for (int k = 0; k < 3; k++) cyc(1'b1, 4'b0101, 4'b0000, 4'b0001);
        found = 1'b0;
        for (int k = 0; k < 80 && !found; k++) begin
            wait_neg();
            if (obs_rise[0]) begin
                apply(1'b1, 4'b0101, 4'b0001, 4'b0001);
                found = 1'b1;
            end else begin
                apply(1'b1, 4'b0101, 4'b0000, 4'b0001);
            end
        end
        check("rise0_seen_in_budget", {31'd0, found}, 32'd1);
        cyc(1'b1, 4'b0101, 4'b0001, 4'b0001);
        check("set_wins_over_clear", {31'd0, obs_ev[0]}, 32'd1);
        cyc(1'b1, 4'b0101, 4'b0000, 4'b0001);
        check("clear_alone", {31'd0, obs_ev[0]}, 32'd0);
        cyc(1'b1, 4'b0101, 4'b0000, 4'b0001);
        check("irq_drops", {31'd0, obs_irq}, 32'd0);

        // Prescaler disabled for 50 cycles while the inputs move.
        wait_neg();
        frozen = obs_out;
        apply(1'b0, 4'($urandom), 4'b0000, 4'b1111);
        for (int k = 0; k < 49; k++) cyc(1'b0, 4'($urandom), 4'b0000, 4'b1111);
        wait_neg();
        check("frozen_while_disabled", {28'd0, obs_out}, {28'd0, frozen});
        apply(1'b1, 4'b1010, 4'b0000, 4'b1111);
        for (int k = 0; k < 40; k++) cyc(1'b1, 4'b1010, 4'b0000, 4'b1111);
        check("resume_after_enable", {28'd0, obs_out}, 32'he);

        // Randomised traffic: slowly toggling inputs, sporadic clears/masks.
        cur_in   = 4'b1010;
        cur_mask = 4'b1111;
        for (int k = 0; k < 600; k++) begin
            for (int b = 0; b < WIDTH; b++) begin
                if ($urandom_range(11) == 0) cur_in[b] = ~cur_in[b];
            end
            if ($urandom_range(31) == 0) cur_mask = 4'($urandom);
            cyc(($urandom_range(9) != 0), cur_in,
                {($urandom_range(7) == 0), ($urandom_range(7) == 0),
                 ($urandom_range(7) == 0), ($urandom_range(7) == 0)}, cur_mask);
        end

        // Drive out to 1011, then reset mid-count.
        for (int k = 0; k < 40; k++) cyc(1'b1, 4'b1111, 4'b0000, 4'b1111);
        check("preset_out_1011", {28'd0, obs_out}, 32'hb);
        cyc(1'b1, 4'b1111, 4'b0000, 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_out", {28'd0, dout}, {28'd0, INIT});
        check("async_reset_event_irq", {27'd0, evt, irq}, 32'd0);
        void'(exp_q.pop_back());
        model_step();
        exp_q.push_back('{out: m_out, rise: m_rise, fall: m_fall, ev: m_ev, irq: m_irq});
        for (int k = 0; k < 3; k++) cyc(1'b1, 4'b0100, 4'b0000, 4'b1111);
        wait_neg();
        rst_n = 1'b1;
        apply(1'b1, 4'b0100, 4'b0000, 4'b1111);
        acc_b = '0;
        acc_c = '0;
        for (int k = 0; k < 30; k++) begin
            cyc(1'b1, 4'b0100, 4'b0000, 4'b1111);
            acc_b |= obs_fall;
            acc_c |= obs_out;
        end
        check("no_fall_after_reset", {28'd0, acc_b}, 32'd0);
        check("out_stays_init", {28'd0, acc_c}, 32'd0);

        @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
